// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared encodings and helpers for the stopwatch core
package stopwatch_pkg;

   typedef logic [7:0] bcd2_t;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_ADJUST  = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   localparam int FIELD_MAX = 59;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stopwatch_core_n_bcd_field.sv
// rtl/stopwatch_core_n_bcd_field.sv - one two-digit BCD field with wrap at MAX
module bcd_field
   import stopwatch_pkg::*;
#(
   parameter int MAX = FIELD_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       clear,
   output bcd2_t      value,
   output logic       carry,
   output logic       borrow
);

   localparam logic [3:0] MAX_TENS = 4'(MAX / 10);
   localparam logic [3:0] MAX_ONES = 4'(MAX % 10);

   logic [3:0] tens;
   logic [3:0] ones;

   assign value  = {tens, ones};
   // Flags depend on state only, so the top can chain them without a comb loop.
   assign carry  = (tens == MAX_TENS) && (ones == MAX_ONES);
   assign borrow = (tens == BCD_ZERO) && (ones == BCD_ZERO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens <= BCD_ZERO;
         ones <= BCD_ZERO;
      end else if (clear) begin
         tens <= BCD_ZERO;
         ones <= BCD_ZERO;
      end else if (inc) begin
         if (carry) begin
            tens <= BCD_ZERO;
            ones <= BCD_ZERO;
         end else if (ones == BCD_NINE) begin
            tens <= tens + 4'd1;
            ones <= BCD_ZERO;
         end else begin
            ones <= ones + 4'd1;
         end
      end else if (dec) begin
         if (borrow) begin
            tens <= MAX_TENS;
            ones <= MAX_ONES;
         end else if (ones == BCD_ZERO) begin
            tens <= tens - 4'd1;
            ones <= BCD_NINE;
         end else begin
            ones <= ones - 4'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_core_n.sv
// rtl/stopwatch_core_n.sv - N-field BCD stopwatch/timer with adjust and lap freeze
module stopwatch_core_n
   import stopwatch_pkg::*;
#(
   parameter int NUM_FIELDS = 2,
   parameter int TOP_MAX    = 59,
   parameter int SEL_W      = sel_width(NUM_FIELDS)
) (
   input  logic                    clk_100mhz,
   input  logic                    rst_n,
   input  logic                    tick_cnt,
   input  logic                    tick_adj,
   input  logic                    clr,
   input  logic                    start_stop,
   input  logic                    count_down,
   input  logic                    adj_en,
   input  logic [SEL_W-1:0]        adj_sel,
   input  logic                    adj_step,
   input  logic                    adj_hold,
   input  logic                    lap,
   output logic [8*NUM_FIELDS-1:0] digits,
   output logic                    running,
   output logic                    adj_active,
   output logic                    lap_frozen,
   output logic                    expired
);

   localparam int CW = 8 * NUM_FIELDS;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [CW-1:0]         count;
   logic [CW-1:0]         snapshot;
   logic                  frozen;
   logic [NUM_FIELDS-1:0] f_inc;
   logic [NUM_FIELDS-1:0] f_dec;
   logic [NUM_FIELDS-1:0] f_carry;
   logic [NUM_FIELDS-1:0] f_borrow;
   logic                  normal;
   logic                  cnt_up;
   logic                  cnt_dn;
   logic                  adj_inc;
   logic                  is_zero;
   logic                  is_one;

   assign normal  = !clr && !adj_en;
   assign cnt_up  = normal && (state == ST_RUN) && tick_cnt && !count_down;
   assign cnt_dn  = normal && (state == ST_RUN) && tick_cnt && count_down;
   assign adj_inc = !clr && adj_en && (state == ST_ADJUST) &&
                    (adj_step || (tick_adj && adj_hold));
   assign is_zero = (count == '0);
   assign is_one  = (count == CW'(1));

   // Count carries ripple through all fields; adjust hits only the selected one.
   always_comb begin
      logic up;
      logic dn;
      up    = cnt_up;
      dn    = cnt_dn;
      f_inc = '0;
      f_dec = '0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         f_inc[i] = up || (adj_inc && (int'(adj_sel) == i));
         f_dec[i] = dn;
         up       = up && f_carry[i];
         dn       = dn && f_borrow[i];
      end
   end

   for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
      localparam int FMAX = (i == NUM_FIELDS - 1) ? TOP_MAX : FIELD_MAX;
      bcd_field #(.MAX(FMAX)) u_field (
         .clk    (clk_100mhz),
         .rst_n  (rst_n),
         .inc    (f_inc[i]),
         .dec    (f_dec[i]),
         .clear  (clr),
         .value  (count[8*i +: 8]),
         .carry  (f_carry[i]),
         .borrow (f_borrow[i])
      );
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = adj_en ? ST_ADJUST : ST_IDLE;
      end else if (adj_en) begin
         state_nxt = ST_ADJUST;
      end else begin
         case (state)
            ST_IDLE:    if (start_stop && !(count_down && is_zero)) state_nxt = ST_RUN;
            ST_RUN:     if (start_stop)            state_nxt = ST_IDLE;
                        else if (cnt_dn && is_one) state_nxt = ST_EXPIRED;
            ST_ADJUST:  state_nxt = ST_IDLE;
            ST_EXPIRED: if (start_stop) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         frozen   <= 1'b0;
         snapshot <= '0;
      end else begin
         state <= state_nxt;
         if (!normal) begin
            frozen <= 1'b0;
         end else if (lap) begin
            if (frozen) begin
               frozen <= 1'b0;
            end else if (state == ST_RUN) begin
               frozen   <= 1'b1;
               snapshot <= count;
            end
         end
      end
   end

   assign digits     = frozen ? snapshot : count;
   assign lap_frozen = frozen;
   assign running    = (state == ST_RUN);
   assign adj_active = (state == ST_ADJUST);
   assign expired    = (state == ST_EXPIRED);

endmodule

// File: doc/stopwatch_core_n.md
# stopwatch_core_n

Parametrised BCD time-keeping core: the next generation of the stopwatch counter. It supports N two-digit fields, up or down counting, expiry detection, per-field adjust with single-step and streaming, and a lap freeze. It sits between the clock divider and debouncers (which supply one-cycle ticks and pulses) and the 7-segment display multiplexer (which consumes `digits`).

## Interface
- `NUM_FIELDS`, 2: number of 2-digit BCD fields; field 0 = seconds, ascending significance (min 1).
- `TOP_MAX`, 59: wrap value of the most-significant field (e.g. 23 for hours); all lower fields wrap at 59.
- `SEL_W`, `$clog2(NUM_FIELDS)` (min 1): width of `adj_sel`.
- `clk_100mhz`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tick_cnt`  in  1: one-cycle count-enable pulse (1 Hz).
- `tick_adj`  in  1: one-cycle adjust-stream pulse (2 Hz).
- `clr`  in  1: debounced clear pulse.
- `start_stop`  in  1: debounced run/stop toggle pulse.
- `count_down`  in  1: level; 1 = countdown, 0 = count up.
- `adj_en`  in  1: level; adjust mode.
- `adj_sel`  in  SEL_W: field to adjust.
- `adj_step`  in  1: debounced single-step pulse.
- `adj_hold`  in  1: debounced level; stream increments on `tick_adj`.
- `lap`  in  1: debounced lap-toggle pulse.
- `digits`  out  8*NUM_FIELDS: displayed BCD; field i at [8i+7:8i], tens in the upper nibble.
- `running`, `adj_active`, `lap_frozen`, `expired`  out  1 each: status.

## Operation
- States: IDLE, RUN, ADJUST, EXPIRED. Reset → IDLE, counter 0, snapshot 0; all outputs 0.
- Per-cycle priority: `clr` > `adj_en` > `start_stop` > `tick_cnt`.
- `clr`: counter := 0, lap released, `expired` := 0. The next state is ADJUST if `adj_en` is high, else IDLE.
- IDLE: `start_stop` → RUN. Exception: if `count_down`=1 and counter = 0, the pulse is ignored.
- RUN:
  - Each `tick_cnt` counts ±1.
  - Up count: a field at its max → 00 with carry. Full rollover (TOP_MAX:59…:59 → all zero) is silent.
  - Down count: a field at 00 → max with borrow.
  - If a down tick makes the counter all-zero → EXPIRED.
  - `start_stop` → IDLE. A `tick_cnt` in the same cycle is still counted.
- EXPIRED: counter held at 0, `tick_cnt` ignored. `start_stop` or `clr` → IDLE.
- ADJUST:
  - Entered from any state when `adj_en`=1. `running`=0 and `expired`=0; lap released.
  - Exiting (`adj_en`=0) → IDLE.
  - `adj_step`, or `tick_adj` while `adj_hold`=1, increments field `adj_sel` by 1. It wraps at that field's max with no carry.
  - Step and stream in the same cycle = one increment.
  - `adj_sel` ≥ NUM_FIELDS: no change.
  - `count_down` is ignored in ADJUST (always increments).
- Lap:
  - `lap` in RUN with no freeze: snapshot := counter, `lap_frozen`=1. `digits` shows the snapshot while counting continues.
  - `lap` while frozen: release.
  - `lap` in IDLE or EXPIRED with no freeze: ignored.
- Outputs: `running`=1 only in RUN; `adj_active`=1 only in ADJUST; `expired`=1 only in EXPIRED.

## Timing
- All state, counter and output changes occur on the `clk_100mhz` edge sampling the input pulse. `digits` and status outputs are registered, visible one edge after the input.
- `rst_n` assertion clears everything immediately without a clock edge. Deassertion is synchronised externally.
- Carry ripples combinationally within one cycle across all fields.
- Pulses are assumed one cycle wide. A level held for k cycles acts as k pulses, except `adj_hold`, which is a level by definition.

## Structure
- `stopwatch_pkg`: state encoding, `FIELD_MAX`=59, BCD nibble constants, and a helper function for SEL_W.
- Sub-module `bcd_field`:
  - Parameter MAX.
  - Inputs: inc, dec, clear.
  - Outputs: 8-bit BCD value, carry/borrow.
  - Instantiated NUM_FIELDS times via generate. The top instance gets MAX=TOP_MAX.
- FSM, lap snapshot and adjust decode live in the top module.

## Test plan
All scenarios use NUM_FIELDS=2 and TOP_MAX=59.
1. Reset, `start_stop`, 61 `tick_cnt` → `digits`=16'h0101, `running`=1.
2. Adjust to 59:59, exit, start, one tick → 16'h0000, `expired`=0, still RUN.
3. Adjust to 00:02, `count_down`=1, start, 2 ticks → 16'h0000, `expired`=1, `running`=0. Then:
   - 3 more ticks → unchanged.
   - `start_stop` → IDLE, `expired`=0.
   - A further `start_stop` is ignored.
4. ADJUST at 00:58, `adj_sel`=0:
   - 3 `adj_step` → 16'h0001 (no carry).
   - Then `adj_sel`=1 with `adj_hold` over 4 `tick_adj` → 16'h0401.
   - `adj_step`+`tick_adj` in the same cycle → 16'h0501.
5. RUN to 00:10, `lap`, 5 ticks → `digits`=16'h0010, `lap_frozen`=1. Then `lap` → 16'h0015.
6. Reset edge cases:
   - `rst_n` low mid-cycle at 00:07 → all outputs 0 before the next edge.
   - `clr`+`start_stop` in the same cycle in RUN → IDLE, 16'h0000.
